// File: rtl/mac_learn_table_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_learn_table_pkg : shared defaults, FSM encodings and learn event type
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
package mac_learn_table_pkg;

  localparam int c_MAX_PORT_NUMBER = 4;
  localparam int c_ADRESS          = 2;
  localparam int c_MAC_W           = 48;
  localparam int c_TABLE_AW        = 6;
  localparam int c_AGE_W           = 3;
  localparam int c_AGE_TICK        = 1000000;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SWEEP = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = c_ST_IDLE,
    ST_SWEEP = c_ST_SWEEP
  } sweep_state_e;

  typedef enum logic [2:0] {
    LRN_NONE    = 3'd0,
    LRN_REFRESH = 3'd1,
    LRN_NEW     = 3'd2,
    LRN_MOVE    = 3'd3,
    LRN_COLL    = 3'd4,
    LRN_DROP    = 3'd5
  } learn_evt_e;

endpackage
`default_nettype wire

// File: rtl/mac_hash.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_hash : XOR-fold of a MAC into a table index, LSB chunk first
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module mac_hash #(
  parameter int pMAC_W    = 48,
  parameter int pTABLE_AW = 6
) (
  input  logic [pMAC_W-1:0]    i_mac,
  output logic [pTABLE_AW-1:0] o_index
);

  localparam int c_NCHUNK = (pMAC_W + pTABLE_AW - 1) / pTABLE_AW;
  localparam int c_PAD_W  = c_NCHUNK * pTABLE_AW;

  // top chunk is zero-padded when the MAC width is not a multiple of the index width
  logic [c_PAD_W-1:0] w_padded;
  assign w_padded = c_PAD_W'(i_mac);

  always_comb begin
    o_index = '0;
    for (int i = 0; i < c_NCHUNK; i++) begin
      o_index = o_index ^ w_padded[i*pTABLE_AW +: pTABLE_AW];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_learn_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mac_learn_table : direct-mapped SA learning table with DA lookup and aging
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module mac_learn_table
  import mac_learn_table_pkg::*;
#(
  parameter int pMAX_PORT_NUMBER = c_MAX_PORT_NUMBER,
  parameter int pADRESS          = c_ADRESS,
  parameter int pMAC_W           = c_MAC_W,
  parameter int pTABLE_AW        = c_TABLE_AW,
  parameter int pAGE_W           = c_AGE_W,
  parameter int pAGE_TICK        = c_AGE_TICK
) (
  input  logic               iclk,
  input  logic               irst,
  input  logic               i_write_en,
  input  logic [pADRESS-1:0] i_port_num,
  input  logic [pMAC_W-1:0]  i_SA,
  input  logic               i_lookup_en,
  input  logic [pMAC_W-1:0]  i_DA,
  output logic               o_lookup_valid,
  output logic               o_lookup_hit,
  output logic [pADRESS-1:0] o_lookup_port,
  output logic               o_learn_new,
  output logic               o_learn_move,
  output logic               o_collision,
  output logic               o_learn_drop,
  output logic               o_aging_active
);

  localparam int                    c_DEPTH     = 2**pTABLE_AW;
  localparam int                    c_TICK_W    = (pAGE_TICK > 1) ? $clog2(pAGE_TICK) : 1;
  localparam logic [c_TICK_W-1:0]   c_TICK_LAST = c_TICK_W'(pAGE_TICK - 1);
  localparam logic [pAGE_W-1:0]     c_AGE_MAX   = '1;
  localparam logic [pTABLE_AW-1:0]  c_IDX_LAST  = '1;

  if ((pMAX_PORT_NUMBER > 2**pADRESS) || (pMAC_W < 41) || (pAGE_TICK < 1)) begin : g_param_check
    $error("mac_learn_table: inconsistent parameters");
  end

  logic [c_DEPTH-1:0] valid_q;
  logic [pMAC_W-1:0]  mac_q  [c_DEPTH];
  logic [pADRESS-1:0] port_q [c_DEPTH];
  logic [pAGE_W-1:0]  age_q  [c_DEPTH];

  sweep_state_e        state_q, state_d;
  logic [pTABLE_AW-1:0] sweep_idx_q, sweep_idx_d;
  logic [c_TICK_W-1:0]  tick_q, tick_d;

  logic [pTABLE_AW-1:0] w_learn_idx;
  logic [pTABLE_AW-1:0] w_lookup_idx;
  learn_evt_e           w_evt;
  logic                 w_learn_wr;
  logic                 w_sweep_hit;
  logic                 w_age_zero;
  logic                 w_hit;

  logic               lookup_valid_q, lookup_hit_q;
  logic [pADRESS-1:0] lookup_port_q;
  logic               learn_new_q, learn_move_q, collision_q, learn_drop_q;

  mac_hash #(.pMAC_W(pMAC_W), .pTABLE_AW(pTABLE_AW)) u_hash_learn (
    .i_mac   (i_SA),
    .o_index (w_learn_idx)
  );

  mac_hash #(.pMAC_W(pMAC_W), .pTABLE_AW(pTABLE_AW)) u_hash_lookup (
    .i_mac   (i_DA),
    .o_index (w_lookup_idx)
  );

  // bit 40 is the I/G bit of the first octet on the wire
  always_comb begin
    w_evt = LRN_NONE;
    if (i_write_en) begin
      if (i_SA[40])                               w_evt = LRN_DROP;
      else if (!valid_q[w_learn_idx])             w_evt = LRN_NEW;
      else if (mac_q[w_learn_idx] != i_SA)        w_evt = LRN_COLL;
      else if (port_q[w_learn_idx] != i_port_num) w_evt = LRN_MOVE;
      else                                        w_evt = LRN_REFRESH;
    end
  end

  assign w_learn_wr  = (w_evt != LRN_NONE) && (w_evt != LRN_DROP);
  assign w_sweep_hit = (state_q == ST_SWEEP) && valid_q[sweep_idx_q] &&
                       !(w_learn_wr && (w_learn_idx == sweep_idx_q));
  assign w_age_zero  = (age_q[sweep_idx_q] == '0);
  assign w_hit       = i_lookup_en && valid_q[w_lookup_idx] && (mac_q[w_lookup_idx] == i_DA);

  always_ff @(posedge iclk) begin
    if (irst) begin
      valid_q <= '0;
    end else begin
      if (w_sweep_hit && w_age_zero) valid_q[sweep_idx_q] <= 1'b0;
      if (w_learn_wr)                valid_q[w_learn_idx] <= 1'b1;
    end
  end

  // payload fields need no reset: every use is gated by the valid bit
  always_ff @(posedge iclk) begin
    if (w_sweep_hit && !w_age_zero) age_q[sweep_idx_q] <= age_q[sweep_idx_q] - pAGE_W'(1);
    if (w_learn_wr) begin
      mac_q[w_learn_idx]  <= i_SA;
      port_q[w_learn_idx] <= i_port_num;
      age_q[w_learn_idx]  <= c_AGE_MAX;
    end
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      sweep_idx_q <= '0;
      tick_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
      tick_q      <= tick_d;
    end
  end

  // a tick wrapping while a sweep is running is simply lost
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    tick_d      = (tick_q == c_TICK_LAST) ? '0 : tick_q + c_TICK_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (tick_q == c_TICK_LAST) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
      ST_SWEEP: begin
        if (sweep_idx_q == c_IDX_LAST) begin
          state_d     = ST_IDLE;
          sweep_idx_d = '0;
        end else begin
          sweep_idx_d = sweep_idx_q + pTABLE_AW'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        sweep_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      lookup_valid_q <= 1'b0;
      lookup_hit_q   <= 1'b0;
      lookup_port_q  <= '0;
      learn_new_q    <= 1'b0;
      learn_move_q   <= 1'b0;
      collision_q    <= 1'b0;
      learn_drop_q   <= 1'b0;
    end else begin
      lookup_valid_q <= i_lookup_en;
      lookup_hit_q   <= w_hit;
      lookup_port_q  <= w_hit ? port_q[w_lookup_idx] : '0;
      learn_new_q    <= (w_evt == LRN_NEW);
      learn_move_q   <= (w_evt == LRN_MOVE);
      collision_q    <= (w_evt == LRN_COLL);
      learn_drop_q   <= (w_evt == LRN_DROP);
    end
  end

  assign o_lookup_valid = lookup_valid_q;
  assign o_lookup_hit   = lookup_hit_q;
  assign o_lookup_port  = lookup_port_q;
  assign o_learn_new    = learn_new_q;
  assign o_learn_move   = learn_move_q;
  assign o_collision    = collision_q;
  assign o_learn_drop   = learn_drop_q;
  assign o_aging_active = (state_q == ST_SWEEP);

endmodule
`default_nettype wire

// File: tb/tb_mac_learn_table.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mac_learn_table : directed stimulus against a behavioural table model
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_mac_learn_table;

  localparam int c_TICK = 16;
  localparam int c_AGEW = 1;
  localparam int c_AW   = 6;
  localparam int c_D    = 64;

  localparam logic [47:0] c_MAC_A = 48'h0011_2233_4455;
  localparam logic [47:0] c_MAC_B = 48'h0011_2233_4414;  // same fold as A
  localparam logic [47:0] c_MAC_C = 48'h0A0B_0C0D_0E0F;
  localparam logic [47:0] c_MAC_M = 48'h0100_5E00_0001;

  logic        clk = 1'b0;
  logic        rst, we, le;
  logic [1:0]  pn;
  logic [47:0] sa, da;
  logic        lv, hit, lnew, lmove, lcoll, ldrop, act;
  logic [1:0]  lport;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  mac_learn_table #(
    .pMAX_PORT_NUMBER (4),
    .pADRESS          (2),
    .pMAC_W           (48),
    .pTABLE_AW        (c_AW),
    .pAGE_W           (c_AGEW),
    .pAGE_TICK        (c_TICK)
  ) dut (
    .iclk           (clk),
    .irst           (rst),
    .i_write_en     (we),
    .i_port_num     (pn),
    .i_SA           (sa),
    .i_lookup_en    (le),
    .i_DA           (da),
    .o_lookup_valid (lv),
    .o_lookup_hit   (hit),
    .o_lookup_port  (lport),
    .o_learn_new    (lnew),
    .o_learn_move   (lmove),
    .o_collision    (lcoll),
    .o_learn_drop   (ldrop),
    .o_aging_active (act)
  );

  always #5 clk = ~clk;

  function automatic int tb_hash(input logic [47:0] m);
    int h;
    h = 0;
    for (int c = 0; c < 8; c++) h = h ^ int'(m[c*6 +: 6]);
    return h;
  endfunction

  // ---- behavioural model: integer bookkeeping of the table and sweep position
  bit          m_valid [c_D];
  logic [47:0] m_mac   [c_D];
  logic [1:0]  m_port  [c_D];
  int          m_age   [c_D];
  int          m_tick, m_sweep, li, si;
  bit          m_wr;
  bit          e_lv, e_hit, e_new, e_move, e_coll, e_drop, e_act;
  logic [1:0]  e_port;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_D; i++) m_valid[i] = 1'b0;
      m_tick = 0; m_sweep = -1;
      {e_lv, e_hit, e_new, e_move, e_coll, e_drop, e_act} = '0;
      e_port = 2'd0;
    end else begin
      li    = tb_hash(da);
      e_lv  = le;
      e_hit = le && m_valid[li] && (m_mac[li] == da);
      e_port = e_hit ? m_port[li] : 2'd0;
      si = tb_hash(sa);
      {e_new, e_move, e_coll, e_drop} = '0;
      m_wr = 1'b0;
      if (we) begin
        if (sa[40]) e_drop = 1'b1;
        else begin
          m_wr = 1'b1;
          if (!m_valid[si])           e_new  = 1'b1;
          else if (m_mac[si] != sa)   e_coll = 1'b1;
          else if (m_port[si] != pn)  e_move = 1'b1;
        end
      end
      if (m_sweep >= 0 && m_valid[m_sweep]) begin
        if (m_age[m_sweep] == 0) m_valid[m_sweep] = 1'b0;
        else m_age[m_sweep] = m_age[m_sweep] - 1;
      end
      if (m_wr) begin
        m_valid[si] = 1'b1; m_mac[si] = sa; m_port[si] = pn; m_age[si] = (1 << c_AGEW) - 1;
      end
      if (m_sweep >= 0) begin
        m_sweep = m_sweep + 1;
        if (m_sweep == c_D) m_sweep = -1;
      end else if (m_tick == c_TICK - 1) begin
        m_sweep = 0;
      end
      m_tick = (m_tick + 1) % c_TICK;
      e_act  = (m_sweep >= 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if ({lv, hit, lport, lnew, lmove, lcoll, ldrop, act} !==
          {e_lv, e_hit, e_port, e_new, e_move, e_coll, e_drop, e_act}) begin
        bad++;
        $display("FAIL model_cmp t=%0t act=%b exp=%b", $time,
                 {lv, hit, lport, lnew, lmove, lcoll, ldrop, act},
                 {e_lv, e_hit, e_port, e_new, e_move, e_coll, e_drop, e_act});
      end
    end
  end

  // ---- stimulus helpers: inputs change at negedge, return one negedge later
  task automatic cyc(input bit r, input bit w, input logic [1:0] p, input logic [47:0] s,
                     input bit l, input logic [47:0] d);
    rst = r; we = w; pn = p; sa = s; le = l; da = d;
    @(negedge clk);
  endtask

  task automatic idle();                                   cyc(1'b0, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0); endtask
  task automatic learn(input logic [47:0] s, input logic [1:0] p); cyc(1'b0, 1'b1, p, s, 1'b0, 48'd0); endtask
  task automatic look(input logic [47:0] d);              cyc(1'b0, 1'b0, 2'd0, 48'd0, 1'b1, d); endtask

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, a, e);
    end
  endtask

  task automatic wait_level(input bit lvl, input string name);
    int n;
    n = 0;
    while (act !== lvl && n < 200) begin idle(); n++; end
    if (act !== lvl) check(name, 32'(act), 32'(lvl));
  endtask

  task automatic sweep_len(input string name);
    int n;
    wait_level(1'b1, {name, "_start"});
    n = 1;
    idle();
    while (act === 1'b1 && n < 200) begin n++; idle(); end
    check(name, n, 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    chk_en = 1'b1;
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    check("reset_outputs", 32'({lv, hit, lport, lnew, lmove, lcoll, ldrop, act}), 32'd0);
    check("model_hash_A", tb_hash(c_MAC_A), 27);
    check("model_hash_B", tb_hash(c_MAC_B), 27);

    look(c_MAC_A);       check("lookup_empty",   32'({lv, hit, lport}), 32'b1000);
    learn(c_MAC_A, 2'd2); check("learn_new",     32'({lnew, lmove, lcoll, ldrop}), 32'b1000);
    look(c_MAC_A);       check("lookup_hit_p2",  32'({lv, hit, lport}), 32'b1110);
    learn(c_MAC_A, 2'd3); check("learn_move",    32'({lnew, lmove, lcoll, ldrop}), 32'b0100);
    look(c_MAC_A);       check("lookup_hit_p3",  32'({lv, hit, lport}), 32'b1111);
    learn(c_MAC_B, 2'd1); check("collision",     32'({lnew, lmove, lcoll, ldrop}), 32'b0010);
    look(c_MAC_A);       check("evicted_miss",   32'({lv, hit, lport}), 32'b1000);
    look(c_MAC_B);       check("lookup_B",       32'({lv, hit, lport}), 32'b1101);
    learn(c_MAC_M, 2'd1); check("mcast_drop",    32'({lnew, lmove, lcoll, ldrop}), 32'b0001);
    look(c_MAC_M);       check("mcast_miss",     32'({lv, hit, lport}), 32'b1000);

    // aging: one unrefreshed entry survives one sweep, gone after the second
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    learn(c_MAC_A, 2'd2);
    sweep_len("sweep1_len");
    look(c_MAC_A);       check("age_survive",    32'({lv, hit, lport}), 32'b1110);
    sweep_len("sweep2_len");
    look(c_MAC_A);       check("age_expired",    32'({lv, hit, lport}), 32'b1000);

    // re-learn exactly when index 27 is visited: age must stay at max
    learn(c_MAC_A, 2'd2);
    sweep_len("sweep3_len");
    wait_level(1'b1, "sweep4_start");
    for (int i = 0; i < 27; i++) idle();
    learn(c_MAC_A, 2'd2); check("refresh_quiet", 32'({lnew, lmove, lcoll, ldrop}), 32'b0000);
    wait_level(1'b0, "sweep4_end");
    look(c_MAC_A);       check("relearn_hit",    32'({lv, hit, lport}), 32'b1110);
    sweep_len("sweep5_len");
    look(c_MAC_A);       check("relearn_keeps",  32'({lv, hit, lport}), 32'b1110);

    // reset in the middle of a sweep with a populated table
    learn(c_MAC_C, 2'd1);
    wait_level(1'b1, "sweep6_start");
    for (int i = 0; i < 10; i++) idle();
    cyc(1'b1, 1'b0, 2'd0, 48'd0, 1'b0, 48'd0);
    check("rst_mid_sweep", 32'({lv, hit, lport, lnew, lmove, lcoll, ldrop, act}), 32'd0);
    look(c_MAC_A);       check("rst_miss_A",     32'({lv, hit, lport}), 32'b1000);
    look(c_MAC_C);       check("rst_miss_C",     32'({lv, hit, lport}), 32'b1000);
    n = 0;
    for (int i = 0; i < 4; i++) begin idle(); n = n + int'(act); end
    check("rst_idle_after", n, 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
